// File: rtl/agc_scaler_pkg.sv
// Shared types and constants for the A1 scaler read-side logic.
// Stage numbering: bit 0 of the scaler bus is FS06.
package agc_scaler_pkg;
    localparam int SCALER_LO_STAGE = 6;
    localparam int HALF_W          = 14;
    localparam int SCALER_W        = 2 * HALF_W;

    typedef enum logic [1:0] {IDLE, SAMP, CMP, DRIVE} rd_state_t;
endpackage

// File: rtl/scaler_settle_sampler.sv
// Double-sampler for the rippling scaler: compares consecutive samples,
// counts mismatches and forces a snapshot (flagging a tear) after MAX_RETRY.
module scaler_settle_sampler
    import agc_scaler_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_samp,
    input  logic                i_cmp,
    input  logic                i_tear_clr,
    input  logic [SCALER_W-1:0] i_data,
    output logic                o_done,
    output logic                o_tear
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [SCALER_W-1:0] r_s0;
    logic [RW-1:0]       r_retry;
    logic                r_tear;
    logic                w_match;
    logic                w_force;

    // The live input acts as the second sample, so a match acknowledges in the same cycle.
    assign w_match = (i_data == r_s0);
    assign w_force = !w_match && (r_retry == RW'(MAX_RETRY));
    assign o_done  = i_cmp && (w_match || w_force);
    assign o_tear  = r_tear;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0    <= '0;
            r_retry <= '0;
            r_tear  <= 1'b0;
        end else begin
            if (i_samp) begin
                r_s0    <= i_data;
                r_retry <= '0;
            end else if (i_cmp && !o_done) begin
                r_s0    <= i_data;
                r_retry <= r_retry + 1'b1;
            end
            if (i_cmp && w_force)
                r_tear <= 1'b1;
            else if (i_tear_clr)
                r_tear <= 1'b0;
        end
    end
endmodule

// File: rtl/scaler_channel_reader.sv
// Serves CHAT/CHBT channel reads with a settled snapshot of scaler stages 6..33;
// a CHAT read also holds the high half so a later CHBT read stays coherent.
module scaler_channel_reader
    import agc_scaler_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic                SIM_CLK,
    input  logic                SIM_RST,
    input  logic [SCALER_W-1:0] SCALER,
    input  logic                RCHAT_,
    input  logic                RCHBT_,
    input  logic                TEAR_CLR,
    output logic [HALF_W-1:0]   CHAT,
    output logic [HALF_W-1:0]   CHBT,
    output logic                RD_ACK,
    output logic                RD_BUSY,
    output logic                RD_TEAR
);
    rd_state_t           r_state, w_next;
    logic                r_a_q, r_a_p, r_b_q, r_b_p;
    logic                r_req_a, r_req_b;
    logic [SCALER_W-1:0] r_snap;
    logic [HALF_W-1:0]   r_hold;
    logic                r_hold_v, r_hold_ack;
    logic                w_edge_a, w_edge_b, w_hold_rd, w_abort;
    logic                w_samp, w_cmp, w_done, w_drv;
    logic [SCALER_W-1:0] w_src;

    assign w_edge_a  = r_a_p && !r_a_q;
    assign w_edge_b  = r_b_p && !r_b_q;
    assign w_hold_rd = w_edge_b && !w_edge_a && r_hold_v;
    // Abort once every strobe that asked for data has gone away.
    assign w_abort   = (!r_req_a || r_a_q) && (!r_req_b || r_b_q);
    assign w_samp    = (r_state == SAMP) && !w_abort;
    assign w_cmp     = (r_state == CMP) && !w_abort;

    scaler_settle_sampler #(.MAX_RETRY(MAX_RETRY)) u_sampler (
        .i_clk      (SIM_CLK),
        .i_rst      (SIM_RST),
        .i_samp     (w_samp),
        .i_cmp      (w_cmp),
        .i_tear_clr (TEAR_CLR),
        .i_data     (SCALER),
        .o_done     (w_done),
        .o_tear     (RD_TEAR)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_edge_a || w_edge_b) w_next = w_hold_rd ? DRIVE : SAMP;
            SAMP:  w_next = w_abort ? IDLE : CMP;
            CMP:   if (w_abort) w_next = IDLE;
                   else if (w_done) w_next = DRIVE;
            DRIVE: if (r_a_q && r_b_q) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Data is valid in the acknowledge cycle itself, straight from the settled input.
    assign w_drv   = (r_state == DRIVE) || w_done;
    assign w_src   = (r_state == DRIVE) ? r_snap : SCALER;
    assign CHAT    = (w_drv && !r_a_q) ? w_src[HALF_W-1:0] : '0;
    assign CHBT    = (w_drv && !r_b_q) ? w_src[SCALER_W-1:HALF_W] : '0;
    assign RD_ACK  = w_done || r_hold_ack;
    assign RD_BUSY = (r_state == SAMP) || (r_state == CMP);

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_state    <= IDLE;
            r_a_q      <= 1'b1;
            r_a_p      <= 1'b1;
            r_b_q      <= 1'b1;
            r_b_p      <= 1'b1;
            r_req_a    <= 1'b0;
            r_req_b    <= 1'b0;
            r_snap     <= '0;
            r_hold     <= '0;
            r_hold_v   <= 1'b0;
            r_hold_ack <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_a_q      <= RCHAT_;
            r_a_p      <= r_a_q;
            r_b_q      <= RCHBT_;
            r_b_p      <= r_b_q;
            r_hold_ack <= (r_state == IDLE) && w_hold_rd;
            if ((r_state == IDLE) && (w_edge_a || w_edge_b)) begin
                r_req_a <= w_edge_a;
                r_req_b <= w_edge_b;
            end
            if ((r_state == IDLE) && w_hold_rd) begin
                r_snap[SCALER_W-1:HALF_W] <= r_hold;
                r_hold_v                  <= 1'b0;
            end
            if (w_done) begin
                r_snap <= SCALER;
                if (r_req_a) begin
                    r_hold   <= SCALER[SCALER_W-1:HALF_W];
                    r_hold_v <= !r_req_b;
                end
            end
        end
    end
endmodule
